ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- EX-stage multiply/divide unit owning the HI/LO register pair; consumes the operands and ALUOp-derived op code from the ID/EX pipeline register.
- Iterative: multiplies take MUL_LATENCY cycles and divides take 33 cycles; MTHI/MTLO complete in one cycle.
- `busy` feeds the hazard unit, which asserts the ID/EX stall while a later instruction needs HI/LO or the unit.
- `flush` from the exception/eret logic kills an in-flight operation.

Parameters:
- MUL_LATENCY, 2, cycles from an accepted MULT/MULTU to the HI/LO write; legal range 1..4.
- XLEN, 32, operand width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  op valid this cycle; sampled only in IDLE.
- flush  in  1  abort the in-flight op and discard its result.
- op  in  4  operation code (muldiv_op_t from the package).
- a  in  32  rs operand (forwarded ID_EX Read_data1).
- b  in  32  rt operand (forwarded ID_EX Read_data2).
- busy  out  1  unit occupied: state != IDLE.
- done  out  1  one-cycle pulse in the cycle after HI/LO are written by a MUL or DIV.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counters=0.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start && !flush && op in {MULT,MULTU}: latch operands, state=MUL, cnt=MUL_LATENCY-1.
  - op in {DIV,DIVU}: latch operands, state=DIV, cnt=31.
  - op=MTHI: hi<=a on the same edge. op=MTLO: lo<=a on the same edge. State stays IDLE.
  - Any other op, or start=0: no change.
- MUL:
  - The 64-bit product is computed from the latched operands (signed for MULT) and held in a pipeline register.
  - When cnt==0: {hi,lo}<=product, done=1, state=IDLE. Otherwise cnt--.
  - Result is visible after edge E0+MUL_LATENCY, where E0 is the accept edge.
- DIV:
  - Radix-2 restoring division on |a| and |b| (raw values for DIVU), one quotient bit per cycle, 32 cycles.
  - Then FIX: negate the quotient if a[31]^b[31], negate the remainder if a[31] (DIV only).
  - lo<=quotient, hi<=remainder, done=1, state=IDLE. Result is visible after E0+33.
- Divide by zero (b==0, both DIV and DIVU): full latency is still used; lo=32'hFFFFFFFF, hi=a (as originally presented).
- Overflow 0x80000000 / -1 (DIV): lo=0x80000000, hi=0.
- start while busy: ignored. The hazard unit must prevent this; the bench asserts it never happens.
- flush:
  - Highest priority in every state: state<=IDLE, hi/lo unchanged, done=0.
  - flush with start in the same cycle: start is dropped, including MTHI/MTLO.
- done is low in every cycle except the one immediately after the completing edge.
- busy is a registered state decode, with no combinational path from start.
- hi/lo read while busy returns the old values; the hazard unit stalls MFHI/MFLO while busy=1.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined:
  - Ops MADD, MADDU, MSUB, MSUBU are accepted and follow the MUL timing.
  - On completion {hi,lo} <= {hi,lo} ± product, using the HI/LO values current at that edge (modulo 2^64).
- Undefined: these op codes are treated as no-ops in IDLE (no busy, no write), and the accumulate adder is not built.

Decomposition:
- Package muldiv_pkg holds:
  - muldiv_op_t (4-bit): NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - State enum.
  - DIV_CYCLES=32.
- One sub-module, muldiv_divider: the iterative restoring core.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, valid.
  - Sign handling and HI/LO update stay in the top.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3, MUL_LATENCY=2 -> busy for 2 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse once.
- DIV a=-7, b=2 -> busy 33 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with the same operands -> lo=0x7FFFFFFC, hi=1.
- DIVU a=0x1234, b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV started, flush at cycle 10 -> busy drops next cycle, hi/lo keep their prior values, no done pulse. Next MTLO a=0x55 -> lo=0x55 one edge later.
- Async reset asserted mid-DIV, deasserted off a clock edge -> hi=lo=0, busy=0 immediately. Next MTHI a=0xA5A5A5A5 -> hi=0xA5A5A5A5.
- (MULDIV_MADD_EN) hi=0, lo=0xFFFFFFFF; MADDU a=1, b=1 -> hi=1, lo=0. Without the macro, the same op leaves hi/lo unchanged and busy stays 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the EX-stage multiply/divide unit.
package muldiv_pkg;

  // Operation codes carried down the ID/EX register.
  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } muldiv_op_t;

  // Unit sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_t;

  // One quotient bit is produced per cycle.
  localparam int DIV_CYCLES = 32;

  // Full 64-bit product, signed when sgn is set (operands sign-extended first).
  function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                        input logic sgn);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = {{32{sgn & x[31]}}, x};
    ye = {{32{sgn & y[31]}}, y};
    return xe * ye;
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative radix-2 restoring divider on unsigned 32-bit magnitudes.
// A start pulse loads the operands; one quotient bit is retired per cycle
// and valid rises after the last bit, staying high until the next start.
module muldiv_divider
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        valid
);

  logic [31:0] rem_r;
  logic [31:0] quot_r;
  logic [31:0] dvs_r;
  logic [5:0]  cnt_r;
  logic        active_r;
  logic        valid_r;
  logic [32:0] shifted_s;
  logic [32:0] diff_s;

  // Trial subtraction of the divisor from the partial remainder shifted left by one.
  always_comb begin
    shifted_s = {rem_r, quot_r[31]};
    diff_s    = shifted_s - {1'b0, dvs_r};
  end

  // Iteration registers: load on start, then restore-or-keep one bit per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_r    <= 32'd0;
      quot_r   <= 32'd0;
      dvs_r    <= 32'd0;
      cnt_r    <= 6'd0;
      active_r <= 1'b0;
      valid_r  <= 1'b0;
    end else if (start) begin
      rem_r    <= 32'd0;
      quot_r   <= dividend;
      dvs_r    <= divisor;
      cnt_r    <= 6'(DIV_CYCLES);
      active_r <= 1'b1;
      valid_r  <= 1'b0;
    end else if (active_r) begin
      if (diff_s[32]) begin
        rem_r  <= shifted_s[31:0];
        quot_r <= {quot_r[30:0], 1'b0};
      end else begin
        rem_r  <= diff_s[31:0];
        quot_r <= {quot_r[30:0], 1'b1};
      end
      cnt_r <= cnt_r - 6'd1;
      if (cnt_r == 6'd1) begin
        active_r <= 1'b0;
        valid_r  <= 1'b1;
      end else begin
        active_r <= 1'b1;
      end
    end else begin
      active_r <= 1'b0;
    end
  end

  assign quotient  = quot_r;
  assign remainder = rem_r;
  assign valid     = valid_r;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when
// MULDIV_MADD_EN is defined; otherwise those codes are no-ops.
// Only XLEN=32 is supported.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  muldiv_state_t state_r, state_s;
  logic [4:0]  cnt_r, cnt_s;
  logic [31:0] a_r, a_s;
  logic [31:0] b_r, b_s;
  logic        sgn_r, sgn_s;
  logic [63:0] prod_r, prod_s;
  logic [31:0] hi_r, hi_s;
  logic [31:0] lo_r, lo_s;
  logic        done_r, done_s;
  logic        busy_r;
`ifdef MULDIV_MADD_EN
  logic        acc_r, acc_s;
  logic        sub_r, sub_s;
`endif

  logic        div_start_s;
  logic [31:0] div_dividend_s;
  logic [31:0] div_divisor_s;
  logic [31:0] div_quot_s;
  logic [31:0] div_rem_s;
  logic        div_valid_s;
  logic        op_signed_s;

  // Magnitudes fed to the divider; signed DIV divides |a| by |b|.
  always_comb begin
    op_signed_s    = (op == OP_DIV);
    div_dividend_s = (op_signed_s && a[31]) ? (32'd0 - a) : a;
    div_divisor_s  = (op_signed_s && b[31]) ? (32'd0 - b) : b;
  end

  muldiv_divider u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start_s),
    .dividend  (div_dividend_s),
    .divisor   (div_divisor_s),
    .quotient  (div_quot_s),
    .remainder (div_rem_s),
    .valid     (div_valid_s)
  );

  // Next-state, HI/LO update and completion decode; flush overrides everything.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    a_s         = a_r;
    b_s         = b_r;
    sgn_s       = sgn_r;
    prod_s      = prod_r;
    hi_s        = hi_r;
    lo_s        = lo_r;
    done_s      = 1'b0;
    div_start_s = 1'b0;
`ifdef MULDIV_MADD_EN
    acc_s       = acc_r;
    sub_s       = sub_r;
`endif
    if (flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                state_s = ST_MUL;
                cnt_s   = 5'(MUL_LATENCY - 1);
                a_s     = a;
                b_s     = b;
                sgn_s   = (op == OP_MULT);
                prod_s  = mul64(a, b, op == OP_MULT);
`ifdef MULDIV_MADD_EN
                acc_s   = 1'b0;
                sub_s   = 1'b0;
`endif
              end
              OP_DIV, OP_DIVU: begin
                state_s     = ST_DIV;
                cnt_s       = 5'd31;
                a_s         = a;
                b_s         = b;
                sgn_s       = (op == OP_DIV);
                div_start_s = 1'b1;
              end
              OP_MTHI: hi_s = a;
              OP_MTLO: lo_s = a;
`ifdef MULDIV_MADD_EN
              OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                state_s = ST_MUL;
                cnt_s   = 5'(MUL_LATENCY - 1);
                a_s     = a;
                b_s     = b;
                sgn_s   = (op == OP_MADD) || (op == OP_MSUB);
                prod_s  = mul64(a, b, (op == OP_MADD) || (op == OP_MSUB));
                acc_s   = 1'b1;
                sub_s   = (op == OP_MSUB) || (op == OP_MSUBU);
              end
`endif
              default: state_s = ST_IDLE;
            endcase
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_r == 5'd0) begin
`ifdef MULDIV_MADD_EN
            if (acc_r && sub_r) begin
              {hi_s, lo_s} = {hi_r, lo_r} - prod_r;
            end else if (acc_r) begin
              {hi_s, lo_s} = {hi_r, lo_r} + prod_r;
            end else begin
              {hi_s, lo_s} = prod_r;
            end
`else
            {hi_s, lo_s} = prod_r;
`endif
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            cnt_s = cnt_r - 5'd1;
          end
        end
        ST_DIV: begin
          if (cnt_r == 5'd0) begin
            state_s = ST_FIX;
          end else begin
            cnt_s = cnt_r - 5'd1;
          end
        end
        ST_FIX: begin
          if (div_valid_s) begin
            if (b_r == 32'd0) begin
              // Divide by zero: all-ones quotient, dividend as presented in HI.
              lo_s = 32'hFFFF_FFFF;
              hi_s = a_r;
            end else begin
              lo_s = (sgn_r && (a_r[31] ^ b_r[31])) ? (32'd0 - div_quot_s) : div_quot_s;
              hi_s = (sgn_r && a_r[31]) ? (32'd0 - div_rem_s) : div_rem_s;
            end
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_FIX;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, operand, result and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      sgn_r   <= 1'b0;
      prod_r  <= 64'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_r   <= 1'b0;
      sub_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      a_r     <= a_s;
      b_r     <= b_s;
      sgn_r   <= sgn_s;
      prod_r  <= prod_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      done_r  <= done_s;
      busy_r  <= (state_s != ST_IDLE);
`ifdef MULDIV_MADD_EN
      acc_r   <= acc_s;
      sub_r   <= sub_s;
`endif
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases followed by
// random operations compared against an arithmetic reference model.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  muldiv_op_t  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [31:0] hi_m;
  logic [31:0] lo_m;
  int          n_checks;
  int          n_fail;

  ex_muldiv_unit #(.MUL_LATENCY(MUL_LAT), .XLEN(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .start (start),
    .flush (flush),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural result of one operation and its latency.
  task automatic model_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] h, input logic [31:0] l,
                          output logic [31:0] nh, output logic [31:0] nl, output int lat);
    longint      sx, sy, q, r;
    logic [63:0] p, ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    nh = h;
    nl = l;
    lat = 0;
    case (o)
      OP_MULT:  begin p = sx * sy; nh = p[63:32]; nl = p[31:0]; lat = MUL_LAT; end
      OP_MULTU: begin p = ux * uy; nh = p[63:32]; nl = p[31:0]; lat = MUL_LAT; end
      OP_DIV: begin
        lat = DIV_LAT;
        if (y == 32'd0) begin nl = 32'hFFFF_FFFF; nh = x; end
        else begin q = sx / sy; r = sx % sy; nl = q[31:0]; nh = r[31:0]; end
      end
      OP_DIVU: begin
        lat = DIV_LAT;
        if (y == 32'd0) begin nl = 32'hFFFF_FFFF; nh = x; end
        else begin uq = ux / uy; ur = ux % uy; nl = uq[31:0]; nh = ur[31:0]; end
      end
      OP_MTHI: nh = x;
      OP_MTLO: nl = x;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        if (o == OP_MADD || o == OP_MSUB) p = sx * sy;
        else p = ux * uy;
        if (o == OP_MSUB || o == OP_MSUBU) p = {h, l} - p;
        else p = {h, l} + p;
        nh = p[63:32];
        nl = p[31:0];
        lat = MUL_LAT;
      end
`endif
      default: lat = 0;
    endcase
  endtask

  // Issue one op and follow it to completion, checking timing and results.
  task automatic run_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    int lat;
    model_op(o, x, y, hi_m, lo_m, eh, el, lat);
    @(negedge clk);
    check_eq("idle_before_start", {63'd0, busy}, 64'd0);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    if (lat == 0) begin
      check_eq("imm_busy", {63'd0, busy}, 64'd0);
      check_eq("imm_done", {63'd0, done}, 64'd0);
      check_eq("imm_hi", {32'd0, hi}, {32'd0, eh});
      check_eq("imm_lo", {32'd0, lo}, {32'd0, el});
    end else begin
      check_eq("accept_busy", {63'd0, busy}, 64'd1);
      check_eq("old_hi", {32'd0, hi}, {32'd0, hi_m});
      check_eq("old_lo", {32'd0, lo}, {32'd0, lo_m});
      for (int k = 1; k <= lat; k++) begin
        @(posedge clk); #1;
        if (k < lat) begin
          check_eq("run_busy", {63'd0, busy}, 64'd1);
          check_eq("run_done", {63'd0, done}, 64'd0);
        end else begin
          check_eq("end_busy", {63'd0, busy}, 64'd0);
          check_eq("end_done", {63'd0, done}, 64'd1);
          check_eq("res_hi", {32'd0, hi}, {32'd0, eh});
          check_eq("res_lo", {32'd0, lo}, {32'd0, el});
        end
      end
      @(posedge clk); #1;
      check_eq("done_pulse_end", {63'd0, done}, 64'd0);
    end
    hi_m = eh;
    lo_m = el;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Time limit: the run must end well before this.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op = OP_NOP;
    a = 32'd0;
    b = 32'd0;
    #22 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);

    // Directed corner cases.
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIVU, 32'h0000_1234, 32'd0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0);

    // Flush in the middle of a divide: no result, no done, busy drops.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_busy", {63'd0, busy}, 64'd0);
    for (int k = 0; k < 36; k++) begin
      check_eq("flush_no_done", {63'd0, done}, 64'd0);
      @(posedge clk); #1;
    end
    check_eq("flush_hi", {32'd0, hi}, {32'd0, hi_m});
    check_eq("flush_lo", {32'd0, lo}, {32'd0, lo_m});
    run_op(OP_MTLO, 32'h0000_0055, 32'd0);

    // Start together with flush is dropped, MTHI and DIV alike.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check_eq("flush_mthi_hi", {32'd0, hi}, {32'd0, hi_m});
    op = OP_DIV; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check_eq("flush_div_busy", {63'd0, busy}, 64'd0);

    // Async reset mid-divide, released away from a clock edge.
    run_op(OP_MTHI, 32'h1357_9BDF, 32'd0);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_hi", {32'd0, hi}, 64'd0);
    check_eq("arst_lo", {32'd0, lo}, 64'd0);
    check_eq("arst_busy", {63'd0, busy}, 64'd0);
    check_eq("arst_done", {63'd0, done}, 64'd0);
    #2 rst_n = 1'b1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    run_op(OP_MTHI, 32'hA5A5_A5A5, 32'd0);

    // Accumulate op: result depends on whether the feature is built.
    run_op(OP_MTHI, 32'd0, 32'd0);
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    run_op(OP_MADDU, 32'd1, 32'd1);
`ifdef MULDIV_MADD_EN
    check_eq("maddu_hi", {32'd0, hi}, 64'd1);
    check_eq("maddu_lo", {32'd0, lo}, 64'd0);
`else
    check_eq("maddu_off_hi", {32'd0, hi}, 64'd0);
    check_eq("maddu_off_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      run_op(muldiv_op_t'($urandom_range(0, 10)), pick_operand(), pick_operand());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
